// File: rtl/restoring_div_seq_if.sv
// Handshake bundle for restoring_div_seq: operand request channel and result channel.
// The divider takes the slave modport; the producer/consumer side takes master.
interface restoring_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// sharing a single WIDTH+1 bit add/sub for every trial subtraction.
module add_sub #(
  parameter int N         = 33,
  parameter int ARCH      = 0,
  parameter int GRP_WIDTH = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         ci,
  output logic [N-1:0] r,
  output logic         co
);
  logic [N-1:0] bx;
  logic         cin;

  // When subtracting, ci acts as borrow-in, so co=1 means "no borrow".
  assign bx  = b ^ {N{sub}};
  assign cin = sub ? ~ci : ci;

  if (ARCH == 0) begin : g_flat
    assign {co, r} = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, cin};
  end else begin : g_grouped
    localparam int NG = (N + GRP_WIDTH - 1) / GRP_WIDTH;
    logic [NG:0] c;
    assign c[0] = cin;
    for (genvar g = 0; g < NG; g++) begin : g_grp
      localparam int LO = g * GRP_WIDTH;
      localparam int HI = (LO + GRP_WIDTH > N) ? N - 1 : LO + GRP_WIDTH - 1;
      assign {c[g+1], r[HI:LO]} = {1'b0, a[HI:LO]} + {1'b0, bx[HI:LO]}
                                  + {{(HI-LO+1){1'b0}}, c[g]};
    end
    assign co = c[NG];
  end
endmodule

module restoring_div_seq #(
  parameter int WIDTH     = 32,
  parameter int ARCH      = 0,
  parameter int GRP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  restoring_div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] divd_q, divd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_a, trial_b, trial_r;
  logic             trial_co;
  logic [WIDTH-1:0] prem_nxt;
  logic             unused_trial_msb;

  assign trial_a = {prem_q, divd_q[WIDTH-1]};
  assign trial_b = {1'b0, dvsr_q};

  add_sub #(
    .N         (WIDTH + 1),
    .ARCH      (ARCH),
    .GRP_WIDTH (GRP_WIDTH)
  ) u_add_sub (
    .a   (trial_a),
    .b   (trial_b),
    .sub (1'b1),
    .ci  (1'b0),
    .r   (trial_r),
    .co  (trial_co)
  );

  // Restore by keeping the shifted value; the top bit is always zero in either branch.
  assign prem_nxt         = trial_co ? trial_r[WIDTH-1:0] : trial_a[WIDTH-1:0];
  assign unused_trial_msb = trial_r[WIDTH];

  // NOTE: every always_comb target gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    divd_d  = divd_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          divd_d = bus.dividend;
          dvsr_d = bus.divisor;
          prem_d = '0;
          cnt_d  = CW'(WIDTH - 1);
          if (bus.divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        prem_d = prem_nxt;
        divd_d = {divd_q[WIDTH-2:0], trial_co};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
          quo_d   = {divd_q[WIDTH-2:0], trial_co};
          rem_d   = prem_nxt;
          dbz_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational logic uses blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      divd_q  <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      divd_q  <= divd_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_div_seq.sv
// Directed-vector bench for restoring_div_seq (WIDTH=32): latency, zero divisor,
// back-pressure, reset abandonment, handshake corner and a short randomized run.
module tb_restoring_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  restoring_div_seq_if #(.WIDTH(W)) bus ();

  restoring_div_seq #(.WIDTH(W), .ARCH(0), .GRP_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold until the accept edge; returns #1 after that edge.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    int guard = 0;
    while (!bus.in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 64'd0, 64'd1);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Edges counted from the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_directed(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                              input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                              input logic exp_dbz, input int exp_lat);
    int lat;
    issue(dvd, dvs);
    wait_valid(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_q"}, 64'(bus.quotient), 64'(exp_q));
    check({tag, "_r"}, 64'(bus.remainder), 64'(exp_r));
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    consume();
    check({tag, "_vld_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int n_results;
    logic [W-1:0] rd, rs, eq, er;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // Reset state, including in_ready high while reset is held
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_q", 64'(bus.quotient), 64'd0);
    check("rst_r", 64'(bus.remainder), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_directed("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_directed("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_directed("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
    run_directed("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);
    run_directed("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);

    // Back-pressure: result held steady with in_ready low
    issue(32'd1000, 32'd3);
    wait_valid(lat);
    check("bp_lat", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      check("bp_q", 64'(bus.quotient), 64'd333);
      check("bp_r", 64'(bus.remainder), 64'd1);
      check("bp_vld", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    consume();
    check("bp_vld_drop", 64'(bus.out_valid), 64'd0);
    check("bp_rdy_back", 64'(bus.in_ready), 64'd1);
    check("bp_q_kept", 64'(bus.quotient), 64'd333);
    check("bp_r_kept", 64'(bus.remainder), 64'd1);

    // Reset 10 cycles into RUN abandons the operation
    issue(32'd5000, 32'd3);
    repeat (9) tick();
    check("mid_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_q", 64'(bus.quotient), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) begin
      tick();
      if (bus.out_valid) check("mid_rst_ghost", 64'(bus.out_valid), 64'd0);
    end
    run_directed("d77_10", 32'd77, 32'd10, 32'd7, 32'd7, 1'b0, 33);

    // in_valid and out_ready together in DONE: release first, accept one edge later
    issue(32'd50, 32'd6);
    wait_valid(lat);
    check("ov_q", 64'(bus.quotient), 64'd8);
    bus.dividend  = 32'd91;
    bus.divisor   = 32'd13;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ov_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("ov_vld_drop", 64'(bus.out_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    check("ov_accepted", 64'(bus.in_ready), 64'd0);
    wait_valid(lat);
    check("ov2_lat", 64'(lat), 64'd33);
    check("ov2_q", 64'(bus.quotient), 64'd7);
    check("ov2_r", 64'(bus.remainder), 64'd0);
    consume();

    // Back-to-back operations with random consumer stalls against a reference
    n_results = 0;
    for (int i = 0; i < 150; i++) begin
      rd = $urandom;
      if (i % 10 == 0)     rs = '0;
      else if (i % 3 == 0) rs = $urandom_range(1, 255);
      else                 rs = $urandom >> $urandom_range(0, 31);
      if (rs == '0) begin
        eq = '1;
        er = rd;
      end else begin
        eq = rd / rs;
        er = rd % rs;
      end
      issue(rd, rs);
      wait_valid(lat);
      if (bus.out_valid) n_results++;
      repeat ($urandom_range(0, 3)) tick();
      check("rnd_q", 64'(bus.quotient), 64'(eq));
      check("rnd_r", 64'(bus.remainder), 64'(er));
      check("rnd_dbz", 64'(bus.div_by_zero), 64'(rs == '0));
      consume();
      if (bus.out_valid) check("rnd_dup", 64'(bus.out_valid), 64'd0);
    end
    check("rnd_count", 64'(n_results), 64'd150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
